stream_mux_n: RTL
=================

Name: stream_mux_n

Overview:
- Parametrised N-input, WIDTH-bit selecting multiplexer with valid/ready handshakes on every input and on the output.
- Has a registered output stage, so input-to-output latency is 1 cycle and throughput is 1 word per cycle.
- Runtime mode: fixed selection through the `sel` port, or round-robin arbitration among valid inputs.
- Used wherever the datapath merges several producers (ALU result, memory read data, immediate, PC+4) onto one registered bus for multi-cycle and pipelined variants of the datapath.

Parameters:
- WIDTH, 32: data width of each channel in bits.
- N, 4: number of input channels, N >= 2.
- SELW, 2: width of `sel` and `out_src`; must equal ceil(log2(N)).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; combinational.
- sel  input  SELW  channel select in fixed mode.
- rr_en  input  1  0 = fixed mode (use `sel`), 1 = round-robin mode.
- out_data  output  WIDTH  registered output data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.
- out_src  output  SELW  registered index of the channel that produced `out_data`.

Behaviour:
- Clock and reset: one clock domain, `clk`. `rst_n` is asynchronous and active-low.
- Reset values (while `rst_n` = 0):
  - out_valid = 0, out_data = 0, out_src = 0.
  - Round-robin pointer `rr_ptr` = 0.
  - in_ready = all 0; forced low combinationally during reset.
- Load enable: `load = !out_valid || out_ready`. The register is either empty or draining this cycle, so back-to-back transfers sustain 1 word per cycle.
- Grant, fixed mode (`rr_en` = 0):
  - `g = sel` if `sel < N` and `in_valid[sel]`; otherwise no grant.
  - Out-of-range `sel` yields no grant and all in_ready = 0.
- Grant, round-robin mode (`rr_en` = 1):
  - `g` is the first i with `in_valid[i]`, searching `rr_ptr`, `rr_ptr+1`, ..., N-1, 0, ..., `rr_ptr-1`.
  - No valid input means no grant.
- in_ready:
  - `in_ready[i] = rst_n && load && (rr_en ? i == g : i == sel)`.
  - In fixed mode the ready of the selected channel is independent of its own valid, so producers never see a valid/ready loop.
  - At most one bit of in_ready is high in any cycle.
- Input transfer on channel i: `in_valid[i] && in_ready[i]` at a rising edge.
  - Next cycle: out_data = in_data[i], out_src = i, out_valid = 1.
  - If `rr_en`: `rr_ptr` <= (i+1) mod N, wrapping from N-1 to 0.
- Output transfer: `out_valid && out_ready`. If no input transfer occurs in the same cycle, out_valid <= 0; out_data and out_src hold their values.
- Simultaneous output and input transfer: the register reloads in the same edge and out_valid stays 1.
- Backpressure: while out_valid = 1 and out_ready = 0, out_data and out_src are stable and all in_ready = 0.
- `rr_ptr` is updated only by granted transfers taken in round-robin mode. Fixed-mode transfers leave it unchanged.
- Mode switch: a change in `rr_en` or `sel` takes effect combinationally for the current cycle's grant. A word already in the output register is unaffected.
- Reset mid-operation: a pending output word is discarded immediately (out_valid drops asynchronously) and `rr_ptr` returns to 0. The first grant after release obeys the reset-state rules.
- Latency: an input accepted at edge k appears with out_valid = 1 after edge k. There is no combinational path from in_data to out_data.
- Width rule: no arithmetic on data. The `rr_ptr` increment is computed in SELW+1 bits and wrapped mod N, so non-power-of-two N works (e.g. N = 3, SELW = 2).

Test Plan:
1. Reset with rst_n = 0 while all in_valid = 1 -> out_valid = 0, out_data = 0, out_src = 0, in_ready = 4'b0000. Release reset, out_ready = 1, rr_en = 0, sel = 2, in_data ch2 = 32'd20 -> one cycle later out_data = 20, out_src = 2.
2. Fixed-mode streaming: sel = 1, in_valid[1] = 1 for 4 cycles with data 10, 11, 12, 13, out_ready = 1 -> out_data sequence 10, 11, 12, 13 on consecutive cycles, out_valid continuously 1.
3. Backpressure: out_valid = 1 holding 32'd100, out_ready = 0 for 3 cycles -> out_data stays 100, in_ready = 0; then out_ready = 1 with ch0 valid at 32'd5 -> next cycle out_data = 5, with no bubble.
4. Round-robin fairness: rr_en = 1, all 4 channels valid continuously, out_ready = 1 -> out_src sequence 0, 1, 2, 3, 0, 1, ...; with only ch1 and ch3 valid -> 1, 3, 1, 3.
5. Edge selects: rr_en = 0 with N = 3 (SELW = 2) and sel = 3 -> in_ready = 0, out_valid stays 0. N = 3 round-robin with all valid -> out_src 0, 1, 2, 0, showing the pointer wrap.
6. Reset mid-stream: out_valid = 1 with data 32'hDEAD and rr_ptr = 2, assert rst_n = 0 between clock edges -> out_valid drops immediately. After release with all valid in round-robin mode -> first out_src = 0.

Source files
------------

// File: rtl/stream_mux_n_if.sv
// Handshake bundle for stream_mux_n: N input channels merged onto one registered output.
interface stream_mux_n_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = 2
);
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [SELW-1:0]    sel;
  logic               rr_en;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [SELW-1:0]    out_src;

  modport master (
    output in_data, in_valid, sel, rr_en, out_ready,
    input  in_ready, out_data, out_valid, out_src
  );

  modport slave (
    input  in_data, in_valid, sel, rr_en, out_ready,
    output in_ready, out_data, out_valid, out_src
  );
endinterface

// File: rtl/stream_mux_n.sv
// N-way valid/ready stream mux with one registered output stage.
// Fixed select via sel, or round-robin arbitration among valid inputs.
module stream_mux_n #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input logic           clk,
  input logic           rst_n,
  stream_mux_n_if.slave bus
);

  logic [N-1:0][WIDTH-1:0] ch_data;
  logic [N-1:0]            rdy;
  logic [SELW-1:0]         rr_ptr, grant_idx;
  logic                    grant_vld, load, xfer;
  logic [SELW:0]           scan_idx, ptr_inc;
  logic [WIDTH-1:0]        out_data_q;
  logic [SELW-1:0]         out_src_q;
  logic                    out_valid_q;

  assign ch_data = bus.in_data;
  assign load    = !out_valid_q || bus.out_ready;

  // Scan from the farthest offset down so the nearest valid channel to rr_ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    if (bus.rr_en) begin
      for (int k = N-1; k >= 0; k--) begin
        scan_idx = {1'b0, rr_ptr} + (SELW+1)'(k);
        if (scan_idx >= (SELW+1)'(N)) scan_idx = scan_idx - (SELW+1)'(N);
        if (bus.in_valid[scan_idx[SELW-1:0]]) begin
          grant_vld = 1'b1;
          grant_idx = scan_idx[SELW-1:0];
        end
      end
    end else if ({1'b0, bus.sel} < (SELW+1)'(N)) begin
      grant_idx = bus.sel;
      grant_vld = bus.in_valid[bus.sel];
    end
  end

  // Fixed-mode ready ignores the channel's own valid to avoid a valid/ready loop.
  always_comb begin
    rdy = '0;
    for (int i = 0; i < N; i++)
      rdy[i] = rst_n && load &&
               (bus.rr_en ? (grant_vld && grant_idx == SELW'(i)) : (bus.sel == SELW'(i)));
  end

  assign xfer    = |(bus.in_valid & rdy);
  assign ptr_inc = {1'b0, grant_idx} + (SELW+1)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      rr_ptr      <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= ch_data[grant_idx];
      out_src_q   <= grant_idx;
      if (bus.rr_en)
        rr_ptr <= (ptr_inc == (SELW+1)'(N)) ? '0 : ptr_inc[SELW-1:0];
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_src   = out_src_q;

endmodule
